// File: rtl/cp0_ctrl_v2_if.sv
// Signal bundle between the MEM/WB pipeline stage and the CP0 controller.
// An exception/eret request is presented whenever exc_code_i != EC_NONE.
// It is consumed on the next clock edge, with no back-pressure.
// The answer is a one-cycle exc_jump_flag strobe carrying exc_jump_addr in the following cycle.
interface cp0_ctrl_v2_if #(
   parameter int NUM_HW_INT = 6
);
   logic                  we_i;
   logic [4:0]            waddr_i;
   logic [31:0]           wdata_i;
   logic                  re_i;
   logic [4:0]            raddr_i;
   logic [31:0]           data_o;
   logic [NUM_HW_INT-1:0] int_i;
   logic [4:0]            exc_code_i;
   logic [31:0]           exc_epc_i;
   logic [31:0]           exc_badvaddr_i;
   logic                  in_delay_i;
   logic                  flush_req;
   logic                  exc_jump_flag;
   logic [31:0]           exc_jump_addr;
   logic                  int_req_o;
   logic                  timer_int_o;
   logic [31:0]           status_o;
   logic [31:0]           cause_o;
   logic [31:0]           epc_o;

   modport master (
      output we_i, waddr_i, wdata_i, re_i, raddr_i, int_i,
             exc_code_i, exc_epc_i, exc_badvaddr_i, in_delay_i,
      input  data_o, flush_req, exc_jump_flag, exc_jump_addr,
             int_req_o, timer_int_o, status_o, cause_o, epc_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, re_i, raddr_i, int_i,
             exc_code_i, exc_epc_i, exc_badvaddr_i, in_delay_i,
      output data_o, flush_req, exc_jump_flag, exc_jump_addr,
             int_req_o, timer_int_o, status_o, cause_o, epc_o
   );
endinterface

// File: rtl/cp0_ctrl_v2.sv
// MiniMIPS32 CP0 system-control coprocessor.
// Provides a prescaled Count/Compare timer, masked interrupt requests and exception entry/eret.
module cp0_ctrl_v2 #(
   parameter int          NUM_HW_INT   = 6,
   parameter int          COUNT_DIV    = 2,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter bit          TIMER_ON_IP7 = 1'b1,
   parameter logic [31:0] STATUS_RST   = 32'h0040_0000,
   parameter logic [4:0]  EC_NONE      = 5'h10,
   parameter logic [4:0]  EC_ERET      = 5'h11
) (
   input  logic         cpu_clk_75M,
   input  logic         cpu_rst,
   cp0_ctrl_v2_if.slave cp0
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [3:0] DIV_LAST     = 4'(COUNT_DIV - 1);

   logic [31:0] badvaddr, count, compare, epc;
   logic [7:0]  im;
   logic        exl, ie;
   logic        bd, ti;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [3:0]  presc;
   logic        jump_flag;
   logic [31:0] jump_addr;

   logic        is_eret, is_exc, wr_en;
   logic        wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic        presc_wrap, count_inc;
   logic [31:0] count_next;
   logic [5:0]  int_ext;
   logic [7:0]  ip_val;
   logic [31:0] status_val, cause_val;
   logic [31:0] rd_badvaddr, rd_count, rd_compare, rd_status, rd_cause, rd_epc;
   logic [31:0] data;

   always_comb begin
      is_eret     = (cp0.exc_code_i == EC_ERET);
      is_exc      = (cp0.exc_code_i != EC_NONE) && !is_eret;
      // Any exception or eret in the same cycle cancels the mtc0.
      wr_en       = cp0.we_i && (cp0.exc_code_i == EC_NONE);
      wr_badvaddr = wr_en && (cp0.waddr_i == REG_BADVADDR);
      wr_count    = wr_en && (cp0.waddr_i == REG_COUNT);
      wr_compare  = wr_en && (cp0.waddr_i == REG_COMPARE);
      wr_status   = wr_en && (cp0.waddr_i == REG_STATUS);
      wr_cause    = wr_en && (cp0.waddr_i == REG_CAUSE);
      wr_epc      = wr_en && (cp0.waddr_i == REG_EPC);

      presc_wrap  = (presc == DIV_LAST);
      count_inc   = !wr_count && presc_wrap;
      count_next  = count + 32'd1;

      int_ext = '0;
      int_ext[NUM_HW_INT-1:0] = cp0.int_i;

      ip_val     = {ip_hw[5] | (ti & TIMER_ON_IP7), ip_hw[4:0], ip_sw};
      status_val = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      cause_val  = {bd, ti, 14'b0, ip_val, 1'b0, exc_code, 2'b0};
   end

   // Read view with the same-cycle mtc0 already applied, so mfc0 sees the masked post-write value.
   always_comb begin
      rd_badvaddr = wr_badvaddr ? cp0.wdata_i : badvaddr;
      rd_count    = wr_count    ? cp0.wdata_i : count;
      rd_compare  = wr_compare  ? cp0.wdata_i : compare;
      rd_epc      = wr_epc      ? cp0.wdata_i : epc;
      rd_status   = wr_status ? {9'b0, 1'b1, 6'b0, cp0.wdata_i[15:8], 6'b0, cp0.wdata_i[1:0]}
                              : status_val;
      rd_cause    = wr_cause  ? {cause_val[31:10], cp0.wdata_i[9:8], cause_val[7:0]}
                              : cause_val;
      data = '0;
      if (cp0.re_i) begin
         case (cp0.raddr_i)
            REG_BADVADDR: data = rd_badvaddr;
            REG_COUNT:    data = rd_count;
            REG_COMPARE:  data = rd_compare;
            REG_STATUS:   data = rd_status;
            REG_CAUSE:    data = rd_cause;
            REG_EPC:      data = rd_epc;
            default:      data = '0;
         endcase
      end
   end

   always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
      if (cpu_rst) begin
         badvaddr  <= '0;
         count     <= '0;
         compare   <= '0;
         epc       <= '0;
         im        <= STATUS_RST[15:8];
         exl       <= STATUS_RST[1];
         ie        <= STATUS_RST[0];
         bd        <= 1'b0;
         ti        <= 1'b0;
         ip_hw     <= '0;
         ip_sw     <= '0;
         exc_code  <= '0;
         presc     <= '0;
         jump_flag <= 1'b0;
         jump_addr <= '0;
      end else begin
         ip_hw <= int_ext;

         if (wr_count) begin
            count <= cp0.wdata_i;
            presc <= '0;
         end else if (presc_wrap) begin
            count <= count_next;
            presc <= '0;
         end else begin
            presc <= presc + 4'd1;
         end

         // A Compare write clears TI even if Count matches on this very edge.
         if (wr_compare) begin
            compare <= cp0.wdata_i;
            ti      <= 1'b0;
         end else if (count_inc && (count_next == compare)) begin
            ti <= 1'b1;
         end

         if (wr_badvaddr) badvaddr <= cp0.wdata_i;
         if (wr_epc)      epc      <= cp0.wdata_i;
         if (wr_cause)    ip_sw    <= cp0.wdata_i[9:8];
         if (wr_status) begin
            im  <= cp0.wdata_i[15:8];
            exl <= cp0.wdata_i[1];
            ie  <= cp0.wdata_i[0];
         end

         jump_flag <= 1'b0;
         jump_addr <= '0;
         if (is_exc) begin
            // A nested exception keeps the EPC/BadVAddr/BD of the outer one.
            if (!exl) begin
               epc      <= cp0.exc_epc_i;
               badvaddr <= cp0.exc_badvaddr_i;
               bd       <= cp0.in_delay_i;
            end
            exc_code  <= cp0.exc_code_i;
            exl       <= 1'b1;
            jump_flag <= 1'b1;
            jump_addr <= EXC_VECTOR;
         end else if (is_eret) begin
            exl       <= 1'b0;
            jump_flag <= 1'b1;
            jump_addr <= epc;
         end
      end
   end

   assign cp0.data_o        = data;
   assign cp0.flush_req     = ~cpu_rst & (cp0.exc_code_i != EC_NONE);
   assign cp0.exc_jump_flag = jump_flag;
   assign cp0.exc_jump_addr = jump_addr;
   assign cp0.int_req_o     = ie & ~exl & (|(ip_val & im));
   assign cp0.timer_int_o   = ti;
   assign cp0.status_o      = status_val;
   assign cp0.cause_o       = cause_val;
   assign cp0.epc_o         = epc;

endmodule

// File: tb/tb_cp0_ctrl_v2.sv
// Bench for cp0_ctrl_v2: directed scenarios plus random traffic against a behavioural model.
// Expected per-cycle outputs are queued and popped by an independent negedge monitor.
module tb_cp0_ctrl_v2;

   localparam int          NUM_HW_INT   = 6;
   localparam int          COUNT_DIV    = 2;
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam bit          TIMER_ON_IP7 = 1'b1;
   localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
   localparam logic [4:0]  EC_NONE      = 5'h10;
   localparam logic [4:0]  EC_ERET      = 5'h11;
   localparam int          W            = 164;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cp0_ctrl_v2_if #(.NUM_HW_INT(NUM_HW_INT)) bus ();

   cp0_ctrl_v2 #(
      .NUM_HW_INT(NUM_HW_INT), .COUNT_DIV(COUNT_DIV), .EXC_VECTOR(EXC_VECTOR),
      .TIMER_ON_IP7(TIMER_ON_IP7), .STATUS_RST(STATUS_RST),
      .EC_NONE(EC_NONE), .EC_ERET(EC_ERET)
   ) dut (
      .cpu_clk_75M(clk),
      .cpu_rst(rst),
      .cp0(bus.slave)
   );

   // stimulus for the current cycle
   logic                  s_rst;
   logic                  s_we, s_re, s_dly;
   logic [4:0]            s_waddr, s_raddr, s_exc;
   logic [31:0]           s_wdata, s_epc, s_bv;
   logic [NUM_HW_INT-1:0] s_int;

   // behavioural model state
   logic [31:0] m_base, m_compare, m_bv, m_epc, m_jaddr;
   int          m_ticks;
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti, m_jflag;
   logic [5:0]  m_hw;
   logic [1:0]  m_sw;
   logic [4:0]  m_code;

   // scoreboard
   logic [W-1:0] exp_q[$];
   int compared   = 0;
   int mismatched = 0;
   bit mon_en     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_count();
      return m_base + 32'(m_ticks / COUNT_DIV);
   endfunction

   function automatic logic [31:0] m_status_val();
      return 32'h0040_0000 | ({24'b0, m_im} << 8) | {30'b0, m_exl, m_ie};
   endfunction

   function automatic logic [31:0] m_cause_val();
      logic [31:0] ip;
      ip = {26'b0, m_hw} | ((TIMER_ON_IP7 && m_ti) ? 32'h20 : 32'h0);
      return ({31'b0, m_bd} << 31) | ({31'b0, m_ti} << 30) | (ip << 10)
           | ({30'b0, m_sw} << 8) | ({27'b0, m_code} << 2);
   endfunction

   function automatic logic [31:0] m_read();
      logic [31:0] bv, cn, cm, st, ca, ep, r;
      bv = m_bv; cn = m_count(); cm = m_compare;
      st = m_status_val(); ca = m_cause_val(); ep = m_epc;
      if (s_we && s_exc == EC_NONE) begin
         case (s_waddr)
            5'd8:  bv = s_wdata;
            5'd9:  cn = s_wdata;
            5'd11: cm = s_wdata;
            5'd12: st = 32'h0040_0000 | (s_wdata & 32'h0000_FF03);
            5'd13: ca = (ca & ~32'h0000_0300) | (s_wdata & 32'h0000_0300);
            5'd14: ep = s_wdata;
            default: ;
         endcase
      end
      r = 32'h0;
      if (s_re) begin
         case (s_raddr)
            5'd8:  r = bv;
            5'd9:  r = cn;
            5'd11: r = cm;
            5'd12: r = st;
            5'd13: r = ca;
            5'd14: r = ep;
            default: r = 32'h0;
         endcase
      end
      return r;
   endfunction

   task automatic model_reset();
      m_base = '0; m_ticks = 0; m_compare = '0; m_bv = '0; m_epc = '0;
      m_im = STATUS_RST[15:8]; m_exl = STATUS_RST[1]; m_ie = STATUS_RST[0];
      m_bd = 1'b0; m_ti = 1'b0; m_hw = '0; m_sw = '0; m_code = '0;
      m_jflag = 1'b0; m_jaddr = '0;
   endtask

   // Effect of one clock edge under the current stimulus.
   task automatic model_advance();
      logic        is_eret, is_exc, wr, inc;
      logic [31:0] c_old, epc_old;
      is_eret = (s_exc == EC_ERET);
      is_exc  = (s_exc != EC_NONE) && !is_eret;
      wr      = s_we && (s_exc == EC_NONE);
      c_old   = m_count();
      epc_old = m_epc;
      inc     = ((m_ticks + 1) % COUNT_DIV) == 0;
      if (wr && s_waddr == 5'd9) begin
         m_base = s_wdata; m_ticks = 0; inc = 1'b0;
      end else begin
         m_ticks++;
      end
      if (wr && s_waddr == 5'd11) begin
         m_compare = s_wdata; m_ti = 1'b0;
      end else if (inc && (c_old + 32'd1) == m_compare) begin
         m_ti = 1'b1;
      end
      m_hw = '0;
      m_hw[NUM_HW_INT-1:0] = s_int;
      if (wr && s_waddr == 5'd8)  m_bv  = s_wdata;
      if (wr && s_waddr == 5'd14) m_epc = s_wdata;
      if (wr && s_waddr == 5'd13) m_sw  = s_wdata[9:8];
      if (wr && s_waddr == 5'd12) begin
         m_im = s_wdata[15:8]; m_exl = s_wdata[1]; m_ie = s_wdata[0];
      end
      m_jflag = 1'b0; m_jaddr = '0;
      if (is_exc) begin
         if (!m_exl) begin
            m_epc = s_epc; m_bv = s_bv; m_bd = s_dly;
         end
         m_code = s_exc; m_exl = 1'b1; m_jflag = 1'b1; m_jaddr = EXC_VECTOR;
      end else if (is_eret) begin
         m_exl = 1'b0; m_jflag = 1'b1; m_jaddr = epc_old;
      end
   endtask

   // driver tasks
   task automatic tick();
      logic flush, ireq;
      logic [31:0] ca;
      @(posedge clk);
      #1;
      rst                = s_rst;
      bus.we_i           = s_we;
      bus.waddr_i        = s_waddr;
      bus.wdata_i        = s_wdata;
      bus.re_i           = s_re;
      bus.raddr_i        = s_raddr;
      bus.int_i          = s_int;
      bus.exc_code_i     = s_exc;
      bus.exc_epc_i      = s_epc;
      bus.exc_badvaddr_i = s_bv;
      bus.in_delay_i     = s_dly;
      if (s_rst) model_reset();
      ca    = m_cause_val();
      flush = !s_rst && (s_exc != EC_NONE);
      ireq  = m_ie && !m_exl && ((ca[15:8] & m_im) != 8'h0);
      exp_q.push_back({m_read(), flush, ireq, m_jflag, m_jaddr, m_ti,
                       m_status_val(), ca, m_epc});
      mon_en = 1'b1;
      if (!s_rst) model_advance();
   endtask

   task automatic set_idle();
      s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_re = 1'b0; s_raddr = '0;
      s_int = '0; s_exc = EC_NONE; s_epc = '0; s_bv = '0; s_dly = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      set_idle(); s_we = 1'b1; s_waddr = a; s_wdata = d; tick();
   endtask

   task automatic raise(input logic [4:0] code, input logic [31:0] epc,
                        input logic [31:0] bv, input logic dly);
      set_idle(); s_exc = code; s_epc = epc; s_bv = bv; s_dly = dly; tick();
   endtask

   task automatic idle_read(input logic [4:0] a);
      set_idle(); s_re = 1'b1; s_raddr = a; tick();
   endtask

   function automatic logic [4:0] pick_addr();
      logic [4:0] tbl [8];
      tbl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
      return tbl[$urandom_range(0, 7)];
   endfunction

   // monitor
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("data_o",        bus.data_o,                   e[163:132]);
            check("flush_req",     {31'b0, bus.flush_req},       {31'b0, e[131]});
            check("int_req_o",     {31'b0, bus.int_req_o},       {31'b0, e[130]});
            check("exc_jump_flag", {31'b0, bus.exc_jump_flag},   {31'b0, e[129]});
            check("exc_jump_addr", bus.exc_jump_addr,            e[128:97]);
            check("timer_int_o",   {31'b0, bus.timer_int_o},     {31'b0, e[96]});
            check("status_o",      bus.status_o,                 e[95:64]);
            check("cause_o",       bus.cause_o,                  e[63:32]);
            check("epc_o",         bus.epc_o,                    e[31:0]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        seen;
      logic [31:0] r;
      set_idle();
      s_rst = 1'b1;
      model_reset();
      bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.re_i = 1'b0;
      bus.raddr_i = '0; bus.int_i = '0; bus.exc_code_i = EC_NONE;
      bus.exc_epc_i = '0; bus.exc_badvaddr_i = '0; bus.in_delay_i = 1'b0;

      // reset with an exception code present: flush must stay low
      repeat (3) begin
         set_idle(); s_exc = 5'h04; tick();
      end
      @(negedge clk);
      check("rst_status", bus.status_o, 32'h0040_0000);
      check("rst_flush",  {31'b0, bus.flush_req}, 32'd0);

      // release, 10 idle clocks, then read Count
      s_rst = 1'b0;
      set_idle(); tick();
      repeat (8) begin set_idle(); tick(); end
      set_idle(); s_raddr = 5'd12; tick();
      @(negedge clk);
      check("data_o_re0", bus.data_o, 32'd0);
      idle_read(5'd9);
      @(negedge clk);
      check("count_after_idle", bus.data_o, 32'd5);

      // timer interrupt
      mtc0(5'd11, 32'd3);
      mtc0(5'd9,  32'd0);
      mtc0(5'd12, 32'h0000_8001);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle_read(5'd9);
         @(negedge clk);
         seen = bus.timer_int_o;
      end
      if (!seen) check("ti_rise_timeout", 32'd0, 32'd1);
      else begin
         check("count_at_ti",  bus.data_o, 32'd3);
         check("int_req_ti",   {31'b0, bus.int_req_o}, 32'd1);
      end
      repeat (3) begin set_idle(); tick(); end
      @(negedge clk);
      check("ti_sticky", {31'b0, bus.timer_int_o}, 32'd1);
      mtc0(5'd11, 32'd100);
      set_idle(); tick();
      @(negedge clk);
      check("ti_cleared",  {31'b0, bus.timer_int_o}, 32'd0);
      check("int_req_clr", {31'b0, bus.int_req_o},   32'd0);

      // exception entry
      raise(5'h04, 32'h8000_0010, 32'h1234_5679, 1'b1);
      @(negedge clk);
      check("flush_same_cycle", {31'b0, bus.flush_req}, 32'd1);
      idle_read(5'd8);
      @(negedge clk);
      check("exc_flag",     {31'b0, bus.exc_jump_flag}, 32'd1);
      check("exc_vector",   bus.exc_jump_addr, 32'hBFC0_0380);
      check("exc_epc",      bus.epc_o, 32'h8000_0010);
      check("exc_bd",       {31'b0, bus.cause_o[31]}, 32'd1);
      check("exc_code",     {27'b0, bus.cause_o[6:2]}, 32'd4);
      check("exc_exl",      {31'b0, bus.status_o[1]}, 32'd1);
      check("exc_badvaddr", bus.data_o, 32'h1234_5679);

      // nested exception, then eret
      raise(5'h0A, 32'h8000_0100, 32'h0000_0BAD, 1'b0);
      set_idle(); tick();
      @(negedge clk);
      check("nested_epc",  bus.epc_o, 32'h8000_0010);
      check("nested_code", {27'b0, bus.cause_o[6:2]}, 32'd10);
      raise(EC_ERET, 32'h0, 32'h0, 1'b0);
      set_idle(); tick();
      @(negedge clk);
      check("eret_flag", {31'b0, bus.exc_jump_flag}, 32'd1);
      check("eret_addr", bus.exc_jump_addr, 32'h8000_0010);
      check("eret_exl",  {31'b0, bus.status_o[1]}, 32'd0);

      // Cause write masking and interrupt masking
      mtc0(5'd13, 32'hFFFF_FFFF);
      mtc0(5'd12, 32'h0000_0401);
      set_idle(); tick();
      @(negedge clk);
      check("cause_ip", bus.cause_o & 32'h0000_FF00, 32'h0000_0300);
      check("int_req_masked", {31'b0, bus.int_req_o}, 32'd0);
      mtc0(5'd12, 32'h0000_0301);
      set_idle(); tick();
      @(negedge clk);
      check("int_req_sw", {31'b0, bus.int_req_o}, 32'd1);

      // mtc0 discarded under exception; bypass read
      set_idle(); s_we = 1'b1; s_waddr = 5'd12; s_wdata = 32'h0; s_exc = 5'h04; tick();
      set_idle(); tick();
      @(negedge clk);
      check("write_discarded", bus.status_o, 32'h0040_0303);
      raise(EC_ERET, 32'h0, 32'h0, 1'b0);
      set_idle(); s_we = 1'b1; s_waddr = 5'd12; s_wdata = 32'h0000_FF01;
      s_re = 1'b1; s_raddr = 5'd12; tick();
      @(negedge clk);
      check("bypass_status", bus.data_o, 32'h0040_FF01);

      // reset in the middle of a redirect
      raise(5'h04, 32'h8000_2000, 32'h0, 1'b0);
      s_rst = 1'b1; set_idle(); tick();
      @(negedge clk);
      check("rst_abandon_flag", {31'b0, bus.exc_jump_flag}, 32'd0);
      check("rst_abandon_addr", bus.exc_jump_addr, 32'd0);
      s_rst = 1'b0; set_idle(); tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         set_idle();
         r = $urandom;
         s_int = r[NUM_HW_INT-1:0];
         if ($urandom_range(0, 2) == 0) begin
            s_we    = 1'b1;
            s_waddr = pick_addr();
            s_wdata = $urandom;
            if (s_waddr == 5'd9 && $urandom_range(0, 1) == 1)
               s_wdata = m_compare - 32'($urandom_range(0, 3));
         end
         s_re    = 1'($urandom_range(0, 1));
         s_raddr = ($urandom_range(0, 3) == 0) ? s_waddr : pick_addr();
         case ($urandom_range(0, 15))
            0:       s_exc = EC_ERET;
            1, 2:    s_exc = 5'($urandom_range(0, 15));
            default: s_exc = EC_NONE;
         endcase
         s_epc = $urandom;
         s_bv  = $urandom;
         s_dly = 1'($urandom_range(0, 1));
         tick();
      end

      set_idle(); tick();
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
